rcswitch_tx_arbiter: RTL

- Shares one rcswitch_send transmitter among N requesters (e.g. a UART command bridge, a receive-to-relay repeater, a periodic beacon).
- Grants requesters round-robin and latches the winner's addr/chan/stat words.
- Sends each frame REPEAT times with an idle GAP between frames, since 433 MHz sockets need several repeats.
- Sits between requester logic and the rcswitch_send instance, in the divided rcswitch clock domain.

---
 rtl/rcswitch_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/rcswitch_tx_arbiter.sv
// rcswitch_tx_arbiter
// ------------------------------------------------------------------------
// Shares one rcswitch_send transmitter among N requesters. Requests are
// granted round-robin. The winner's addr/chan/stat words are latched once,
// and the frame is sent REPEAT times with GAP idle cycles between frames.
// This block runs in the divided rcswitch clock domain.
//
// Optional feature (macro RCSWITCH_TX_ARB_TIMEOUT_EN):
//   A 12-bit watchdog guards the WAIT_BUSY and WAIT_DONE states. When it
//   expires, it sets the sticky err flag and forces DONE, so the grant is
//   still released. Without the macro, err is tied low and those states
//   wait indefinitely.
//
// Parameters:
//   N        number of requesters (2..8)
//   REPEAT   frames per granted request (1..15)
//   GAP      idle clk cycles between frames (1..255)
//   TIMEOUT  watchdog limit per tx_ready phase (1..4095)
//
// Ports:
//   clk       rcswitch clock
//   rst       asynchronous active-low reset
//   req       per-requester level request, held until done
//   req_addr  packed 40-bit addr words, requester i at [i*40 +: 40]
//   req_chan  packed 40-bit chan words, requester i at [i*40 +: 40]
//   req_stat  packed 16-bit stat words, requester i at [i*16 +: 16]
//   gnt       one-hot grant, high from LOAD through DONE
//   done      one-cycle completion pulse to the granted requester
//   busy      high whenever the arbiter is not idle
//   err       sticky watchdog flag (0 unless the optional feature is built)
//   tx_send   one-cycle start pulse to rcswitch_send
//   tx_addr   latched addr word
//   tx_chan   latched chan word
//   tx_stat   latched stat word
//   tx_ready  rcswitch_send idle flag, low while a frame is on air
module rcswitch_tx_arbiter #(
    parameter int N       = 4,
    parameter int REPEAT  = 4,
    parameter int GAP     = 10,
    parameter int TIMEOUT = 4095
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*40-1:0] req_addr,
    input  logic [N*40-1:0] req_chan,
    input  logic [N*16-1:0] req_stat,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic            busy,
    output logic            err,
    output logic            tx_send,
    output logic [39:0]     tx_addr,
    output logic [39:0]     tx_chan,
    output logic [15:0]     tx_stat,
    input  logic            tx_ready
);

    localparam int         PW          = $clog2(N);
    localparam logic [PW:0] N_W        = (PW+1)'(N);
    localparam logic [3:0] REPEAT_INIT = 4'(REPEAT);
    localparam logic [7:0] GAP_INIT    = 8'(GAP);

    // Reject parameter values that the counters cannot represent
    if (N < 2 || N > 8) begin : g_bad_n
        $error("rcswitch_tx_arbiter: N must be 2..8");
    end
    if (REPEAT < 1 || REPEAT > 15) begin : g_bad_repeat
        $error("rcswitch_tx_arbiter: REPEAT must be 1..15");
    end
    if (GAP < 1 || GAP > 255) begin : g_bad_gap
        $error("rcswitch_tx_arbiter: GAP must be 1..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 4095) begin : g_bad_timeout
        $error("rcswitch_tx_arbiter: TIMEOUT must be 1..4095");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARB       = 3'd1,
        S_LOAD      = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_GAP       = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t        state_r;
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] win_r;
    logic [3:0]    rep_cnt_r;
    logic [7:0]    gap_cnt_r;

    logic          win_found_s;
    logic [PW-1:0] win_idx_s;
    logic [N-1:0]  win_onehot_s;
    logic [PW-1:0] ptr_next_s;
    logic [PW:0]   sum_s;
    logic [PW:0]   cand_s;
    logic          hit_s;

`ifdef RCSWITCH_TX_ARB_TIMEOUT_EN
    localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT - 1);
    logic [11:0] wdog_r;
`else
    assign err = 1'b0;
`endif

    // Round-robin search: first set request at or after ptr_r, wrapping at N
    always_comb begin
        win_found_s  = 1'b0;
        win_idx_s    = '0;
        sum_s        = '0;
        cand_s       = '0;
        hit_s        = 1'b0;
        win_onehot_s = '0;
        for (int k = 0; k < N; k++) begin
            sum_s       = {1'b0, ptr_r} + (PW+1)'(k);
            cand_s      = (sum_s >= N_W) ? (sum_s - N_W) : sum_s;
            hit_s       = !win_found_s && req[cand_s[PW-1:0]];
            win_idx_s   = hit_s ? cand_s[PW-1:0] : win_idx_s;
            win_found_s = win_found_s | hit_s;
        end
        win_onehot_s[win_idx_s] = 1'b1;
        ptr_next_s = (win_idx_s == PW'(N - 1)) ? '0 : (win_idx_s + PW'(1));
    end

    // Arbiter FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            ptr_r     <= '0;
            win_r     <= '0;
            rep_cnt_r <= 4'd0;
            gap_cnt_r <= 8'd0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            tx_send   <= 1'b0;
            tx_addr   <= 40'd0;
            tx_chan   <= 40'd0;
            tx_stat   <= 16'd0;
`ifdef RCSWITCH_TX_ARB_TIMEOUT_EN
            wdog_r    <= 12'd0;
            err       <= 1'b0;
`endif
        end else begin
            // Pulse outputs fall back to zero unless a state raises them
            tx_send <= 1'b0;
            done    <= '0;
            case (state_r)
                S_IDLE: begin
                    // A frame already on air is never interrupted
                    if ((req != '0) && tx_ready) begin
                        state_r <= S_ARB;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ARB: begin
                    if (win_found_s) begin
                        win_r     <= win_idx_s;
                        ptr_r     <= ptr_next_s;
                        rep_cnt_r <= REPEAT_INIT;
                        gnt       <= win_onehot_s;
                        state_r   <= S_LOAD;
                    end else begin
                        // Request withdrawn before arbitration
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    tx_addr <= req_addr[int'(win_r)*40 +: 40];
                    tx_chan <= req_chan[int'(win_r)*40 +: 40];
                    tx_stat <= req_stat[int'(win_r)*16 +: 16];
                    tx_send <= 1'b1;
                    state_r <= S_SEND;
                end
                S_SEND: begin
`ifdef RCSWITCH_TX_ARB_TIMEOUT_EN
                    wdog_r  <= 12'd0;
`endif
                    state_r <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!tx_ready) begin
`ifdef RCSWITCH_TX_ARB_TIMEOUT_EN
                        wdog_r  <= 12'd0;
`endif
                        state_r <= S_WAIT_DONE;
                    end
`ifdef RCSWITCH_TX_ARB_TIMEOUT_EN
                    else if (wdog_r == TIMEOUT_LAST) begin
                        err       <= 1'b1;
                        done      <= gnt;
                        rep_cnt_r <= 4'd0;
                        state_r   <= S_DONE;
                    end else begin
                        wdog_r <= wdog_r + 12'd1;
                    end
`else
                    else begin
                        state_r <= S_WAIT_BUSY;
                    end
`endif
                end
                S_WAIT_DONE: begin
                    if (tx_ready) begin
                        if (rep_cnt_r == 4'd1) begin
                            rep_cnt_r <= 4'd0;
                            done      <= gnt;
                            state_r   <= S_DONE;
                        end else begin
                            rep_cnt_r <= rep_cnt_r - 4'd1;
                            gap_cnt_r <= GAP_INIT;
                            state_r   <= S_GAP;
                        end
                    end
`ifdef RCSWITCH_TX_ARB_TIMEOUT_EN
                    else if (wdog_r == TIMEOUT_LAST) begin
                        err       <= 1'b1;
                        done      <= gnt;
                        rep_cnt_r <= 4'd0;
                        state_r   <= S_DONE;
                    end else begin
                        wdog_r <= wdog_r + 12'd1;
                    end
`else
                    else begin
                        state_r <= S_WAIT_DONE;
                    end
`endif
                end
                S_GAP: begin
                    // GAP cycles are spent here; tx_* stay untouched
                    if (gap_cnt_r <= 8'd1) begin
                        gap_cnt_r <= 8'd0;
                        tx_send   <= 1'b1;
                        state_r   <= S_SEND;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                    end
                end
                S_DONE: begin
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
